// File: rtl/ram_demo_pkg.sv
// Shared types and helpers for the RAM fill-then-check controller and its checker.
package ram_demo_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WRITE = 3'd1,
        S_GAP   = 3'd2,
        S_READ  = 3'd3,
        S_FLUSH = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    localparam int ERR_W = 8;

    // Callers truncate the result to the RAM data width.
    function automatic logic [31:0] pat(input logic [31:0] addr, input logic [31:0] seed);
        return addr + seed;
    endfunction

endpackage

// File: rtl/ram_rd_checker.sv
// Read-side checker: delays rd_flag/address by the RAM read latency, compares returned data
// against the pattern, counts mismatches (saturating) and latches the first failing address.
module ram_rd_checker
    import ram_demo_pkg::*;
#(
    parameter int              AW     = 6,
    parameter int              DW     = 8,
    parameter int              RD_LAT = 1,
    parameter logic [DW-1:0]   SEED   = '0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clr_i,
    input  logic              rd_flag_i,
    input  logic [AW-1:0]     rd_addr_i,
    input  logic [DW-1:0]     rd_data_i,
    output logic [ERR_W-1:0]  err_cnt_o,
    output logic [AW-1:0]     first_err_addr_o
);

    logic [RD_LAT-1:0] vld_q;
    logic [AW-1:0]     addr_q [RD_LAT];
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [AW-1:0]     first_q, first_d;
    logic              mismatch;
    logic [DW-1:0]     expect_dat;

    always_comb begin
        expect_dat = DW'(pat(32'(addr_q[RD_LAT-1]), 32'(SEED)));
        mismatch   = vld_q[RD_LAT-1] && (rd_data_i != expect_dat);
        err_cnt_d  = err_cnt_q;
        first_d    = first_q;
        if (clr_i) begin
            err_cnt_d = '0;
            first_d   = '0;
        end else if (mismatch) begin
            if (err_cnt_q != {ERR_W{1'b1}}) begin
                err_cnt_d = err_cnt_q + 1'b1;
            end
            // The count only ever grows within a pass, so zero means no earlier failure.
            if (err_cnt_q == '0) begin
                first_d = addr_q[RD_LAT-1];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vld_q     <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                addr_q[i] <= '0;
            end
            err_cnt_q <= '0;
            first_q   <= '0;
        end else begin
            vld_q[0]  <= rd_flag_i;
            addr_q[0] <= rd_addr_i;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i]  <= vld_q[i-1];
                addr_q[i] <= addr_q[i-1];
            end
            err_cnt_q <= err_cnt_d;
            first_q   <= first_d;
        end
    end

    assign err_cnt_o        = err_cnt_q;
    assign first_err_addr_o = first_q;

endmodule

// File: rtl/ram_bist_ctrl.sv
// One fill-then-check pass over a dual-port RAM: writes addr+SEED to every word, waits,
// raises rd_flag for DEPTH cycles, drains the compare pipeline and pulses done.
module ram_bist_ctrl
    import ram_demo_pkg::*;
#(
    parameter int            AW     = 6,
    parameter int            DW     = 8,
    parameter int            RD_LAT = 1,
    parameter logic [DW-1:0] SEED   = '0,
    parameter int            GAP    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              ram_wr_en,
    output logic [AW-1:0]     ram_wr_addr,
    output logic [DW-1:0]     ram_wr_data,
    output logic              rd_flag,
    input  logic [AW-1:0]     ram_rd_addr,
    input  logic [DW-1:0]     ram_rd_data,
    output logic              busy,
    output logic              done,
    output logic [ERR_W-1:0]  err_cnt,
    output logic [AW-1:0]     first_err_addr
);

    localparam int           CNT_W     = AW + 1;
    localparam logic [AW:0]  CNT_DEPTH = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0]  GAP_END   = CNT_W'(GAP - 1);
    localparam logic [AW:0]  FLUSH_END = CNT_W'(RD_LAT - 1);

    state_t         state_q;
    logic [AW:0]    cnt_q;
    logic           wr_en_q, rd_flag_q, busy_q, done_q;
    logic [AW-1:0]  wr_addr_q;
    logic [DW-1:0]  wr_data_q;
    logic           start_acc;

    assign start_acc = start && ((state_q == S_IDLE) || (state_q == S_DONE));

    // cnt_q is one bit wider than the address so reaching DEPTH is distinguishable from 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            rd_flag_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_acc) begin
                        state_q   <= S_WRITE;
                        cnt_q     <= CNT_W'(1);
                        wr_en_q   <= 1'b1;
                        wr_addr_q <= '0;
                        wr_data_q <= DW'(pat(32'd0, 32'(SEED)));
                        busy_q    <= 1'b1;
                    end
                end
                S_WRITE: begin
                    if (cnt_q == CNT_DEPTH) begin
                        wr_en_q <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_GAP;
                    end else begin
                        wr_addr_q <= cnt_q[AW-1:0];
                        wr_data_q <= DW'(pat(32'(cnt_q), 32'(SEED)));
                        cnt_q     <= cnt_q + 1'b1;
                    end
                end
                S_GAP: begin
                    if (cnt_q == GAP_END) begin
                        rd_flag_q <= 1'b1;
                        cnt_q     <= CNT_W'(1);
                        state_q   <= S_READ;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_READ: begin
                    if (cnt_q == CNT_DEPTH) begin
                        rd_flag_q <= 1'b0;
                        cnt_q     <= '0;
                        state_q   <= S_FLUSH;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FLUSH: begin
                    if (cnt_q == FLUSH_END) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    ram_rd_checker #(
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT),
        .SEED   (SEED)
    ) u_chk (
        .clk_i            (clk),
        .rst_i            (rst),
        .clr_i            (start_acc),
        .rd_flag_i        (rd_flag_q),
        .rd_addr_i        (ram_rd_addr),
        .rd_data_i        (ram_rd_data),
        .err_cnt_o        (err_cnt),
        .first_err_addr_o (first_err_addr)
    );

    assign ram_wr_en   = wr_en_q;
    assign ram_wr_addr = wr_addr_q;
    assign ram_wr_data = wr_data_q;
    assign rd_flag     = rd_flag_q;
    assign busy        = busy_q;
    assign done        = done_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Bench: RAM + sequential reader models around two controllers (SEED 0 and SEED F0).
module tb_ram_bist_ctrl;

    localparam int         AW     = 6;
    localparam int         DW     = 8;
    localparam int         RD_LAT = 1;
    localparam int         GAP    = 4;
    localparam int         DEPTH  = 64;
    localparam logic [7:0] SEED0  = 8'h00;
    localparam logic [7:0] SEED1  = 8'hF0;
    localparam int         T_DONE = DEPTH + GAP + DEPTH + RD_LAT + 1;

    logic clk = 1'b0, rst = 1'b1, start0 = 1'b0, start1 = 1'b0;
    always #5 clk = ~clk;

    logic          wr_en0, rd_flag0, busy0, done0, wr_en1, rd_flag1, busy1, done1;
    logic [AW-1:0] wr_addr0, rd_addr0, first0, wr_addr1, rd_addr1, first1;
    logic [DW-1:0] wr_data0, rd_data0, wr_data1, rd_data1;
    logic [7:0]    err0, err1;

    ram_bist_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .SEED(SEED0), .GAP(GAP)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0),
        .ram_wr_en(wr_en0), .ram_wr_addr(wr_addr0), .ram_wr_data(wr_data0),
        .rd_flag(rd_flag0), .ram_rd_addr(rd_addr0), .ram_rd_data(rd_data0),
        .busy(busy0), .done(done0), .err_cnt(err0), .first_err_addr(first0));

    ram_bist_ctrl #(.AW(AW), .DW(DW), .RD_LAT(RD_LAT), .SEED(SEED1), .GAP(GAP)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1),
        .ram_wr_en(wr_en1), .ram_wr_addr(wr_addr1), .ram_wr_data(wr_data1),
        .rd_flag(rd_flag1), .ram_rd_addr(rd_addr1), .ram_rd_data(rd_data1),
        .busy(busy1), .done(done1), .err_cnt(err1), .first_err_addr(first1));

    // RAM and reader models; bad[] forces a word to read back as 0xFF.
    logic [DW-1:0] mem0 [DEPTH];
    logic [DW-1:0] mem1 [DEPTH];
    bit            bad  [DEPTH];

    always @(posedge clk) begin
        if (wr_en0) mem0[wr_addr0] <= wr_data0;
        rd_data0 <= bad[rd_addr0] ? 8'hFF : mem0[rd_addr0];
        rd_addr0 <= (rst || !rd_flag0) ? '0 : rd_addr0 + 1'b1;
        if (wr_en1) mem1[wr_addr1] <= wr_data1;
        rd_data1 <= mem1[rd_addr1];
        rd_addr1 <= (rst || !rd_flag1) ? '0 : rd_addr1 + 1'b1;
    end

    int checks = 0;
    int passes = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    // Model of DUT0: t = cycles since the accepted start edge; results from RAM contents.
    bit         m_act = 1'b0;
    int         t = 0;
    logic [7:0] m_err = '0;
    logic [5:0] m_first = '0;

    task automatic model_result();
        logic [7:0] word;
        m_err = '0;
        m_first = '0;
        for (int a = 0; a < DEPTH; a++) begin
            word = bad[a] ? 8'hFF : mem0[a];
            if (word != 8'(a) + SEED0) begin
                if (m_err == 8'd0) m_first = 6'(a);
                if (m_err != 8'hFF) m_err = m_err + 8'd1;
            end
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_act = 1'b0; t = 0; m_err = '0; m_first = '0;
        end else if (start0 && !(m_act && t < T_DONE)) begin
            m_act = 1'b1; t = 1; m_err = '0; m_first = '0;
        end else if (m_act) begin
            if (t < 1000) t++;
            if (t == T_DONE) model_result();
        end
    end

    bit chk_on = 1'b0;
    bit e_wr, e_rd, e_busy, e_done;

    always @(negedge clk) begin
        if (chk_on) begin
            e_wr   = m_act && t >= 1 && t <= DEPTH;
            e_rd   = m_act && t >= DEPTH + GAP + 1 && t <= 2 * DEPTH + GAP;
            e_busy = m_act && t >= 1 && t < T_DONE;
            e_done = m_act && t == T_DONE;
            chk("cycle_outputs",
                64'({wr_en0, rd_flag0, busy0, done0,
                     e_wr ? wr_addr0 : 6'd0, e_wr ? wr_data0 : 8'd0}),
                64'({e_wr, e_rd, e_busy, e_done,
                     e_wr ? 6'(t - 1) : 6'd0, e_wr ? 8'(t - 1) + SEED0 : 8'd0}));
            if (!m_act || t == 1 || t >= T_DONE)
                chk("err_state", 64'({err0, first0}), 64'({m_err, m_first}));
        end
    end

    // Starts a pass on DUT0 (which=0) or DUT1 and waits for done; poke re-pulses start.
    task automatic run_pass(input bit which, input int poke, output int dcyc,
                            output int nwr, output int nrd);
        dcyc = 0; nwr = 0; nrd = 0;
        if (which) start1 = 1'b1; else start0 = 1'b1;
        do begin
            @(negedge clk);
            start0 = 1'b0; start1 = 1'b0;
            dcyc++;
            nwr += which ? int'(wr_en1) : int'(wr_en0);
            nrd += which ? int'(rd_flag1) : int'(rd_flag0);
            if (dcyc == 1 && !which) chk("err_cleared_on_start", 64'({err0, first0}), 64'(0));
            if (dcyc == poke) start0 = 1'b1;
        end while (!(which ? done1 : done0) && dcyc < 400);
    endtask

    int dcyc, nwr, nrd, quiet;
    bit found;

    initial begin
        foreach (bad[i]) bad[i] = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_outputs",
            64'({wr_en0, wr_addr0, wr_data0, rd_flag0, busy0, done0, err0, first0}), 64'(0));
        chk_on = 1'b1;
        rst = 1'b0;
        quiet = 0;
        repeat (20) begin
            @(negedge clk);
            quiet += int'(wr_en0) + int'(rd_flag0) + int'(busy0);
        end
        chk("idle_quiet", 64'(quiet), 64'(0));

        run_pass(1'b0, 0, dcyc, nwr, nrd);
        chk("clean_done_cycle", 64'(dcyc), 64'(134));
        chk("clean_writes", 64'(nwr), 64'(64));
        chk("clean_reads", 64'(nrd), 64'(64));
        chk("clean_err", 64'({err0, first0}), 64'(0));
        chk("mem_word_2a", 64'(mem0[6'h2A]), 64'(8'h2A));

        bad[6'h2A] = 1'b1;
        run_pass(1'b0, 0, dcyc, nwr, nrd);
        chk("one_bad_err", 64'(err0), 64'(1));
        chk("one_bad_first", 64'(first0), 64'(6'h2A));
        bad[6'h2A] = 1'b0;

        bad[5] = 1'b1; bad[9] = 1'b1;
        run_pass(1'b0, 0, dcyc, nwr, nrd);
        chk("two_bad_err", 64'(err0), 64'(2));
        chk("two_bad_first", 64'(first0), 64'(5));
        bad[5] = 1'b0; bad[9] = 1'b0;
        run_pass(1'b0, 0, dcyc, nwr, nrd);
        chk("rerun_clean", 64'({err0, first0}), 64'(0));

        start0 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            start0 = 1'b0;
            found = wr_en0 && (wr_addr0 == 6'd30);
        end
        chk("reached_addr30", 64'(found), 64'(1));
        rst = 1'b1;
        @(negedge clk);
        chk("abort_outputs", 64'({wr_en0, rd_flag0, busy0, done0}), 64'(0));
        rst = 1'b0;
        @(negedge clk);
        run_pass(1'b0, 0, dcyc, nwr, nrd);
        chk("after_abort_cycle", 64'(dcyc), 64'(134));
        chk("after_abort_err", 64'(err0), 64'(0));

        run_pass(1'b0, 80, dcyc, nwr, nrd);
        chk("start_in_read_cycle", 64'(dcyc), 64'(134));
        chk("start_in_read_reads", 64'(nrd), 64'(64));

        run_pass(1'b1, 0, dcyc, nwr, nrd);
        chk("seedf0_done_cycle", 64'(dcyc), 64'(134));
        chk("seedf0_word20", 64'(mem1[6'h20]), 64'(8'h10));
        chk("seedf0_word00", 64'(mem1[6'h00]), 64'(8'hF0));
        chk("seedf0_err", 64'({err1, first1}), 64'(0));

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
